// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS32 main control FSM.
// Opcodes, state codes, mux-select codes and the decoded control word.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ORIEX   = 4'd11,
        S_IMMWB   = 4'd12
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OR    = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_RS     = 2'b11;

    localparam logic [1:0] SRCB_B   = 2'b00;
    localparam logic [1:0] SRCB_4   = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;
    localparam logic [1:0] SRCB_BR  = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       zero_ext;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_R)   || (op == OP_LW)   || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J)    ||
               (op == OP_ADDI) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Pure Moore decode of the FSM state into the datapath control word.
// Handshake-dependent strobes are emitted ungated; the FSM top qualifies them.
module mc_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state,
    output ctrl_t      ctrl
);

    // Per-state control word; unused encodings fall through to all zeros
    always_comb begin
        ctrl = '0;
        case (state_t'(state))
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_4;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCS_ALU;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_BR;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCS_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCS_JUMP;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_ORIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_OR;
                ctrl.zero_ext  = 1'b1;
            end
            S_IMMWB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS32 datapath.
// Holds the state register, next-state logic and the mem_ready/jr/reset gating.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       jr,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       zero_ext,
    output logic [1:0] alu_op,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    state_t state_q;
    state_t state_d;
    ctrl_t  base;
    ctrl_t  ctrl;
    logic   illegal;

    mc_ctrl_decode u_decode (
        .state (state_q),
        .ctrl  (base)
    );

    // Next state from current state, latched opcode and handshakes
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_ORI:       state_d = S_ORIEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_LW)
                    state_d = S_MEMRD;
                else if (opcode == OP_SW)
                    state_d = S_MEMWR;
                else
                    state_d = S_FETCH;
            end
            S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE: state_d = jr ? S_FETCH : S_ALUWB;
            S_ADDIEX:  state_d = S_IMMWB;
            S_ORIEX:   state_d = S_IMMWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= state_t'(RESET_STATE);
        else
            state_q <= state_d;
    end

    // Qualify the Moore word with mem_ready, jr and reset
    always_comb begin
        ctrl    = base;
        illegal = (state_q == S_DECODE) && !is_legal_op(opcode);
        if (state_q == S_FETCH) begin
            ctrl.ir_write = mem_ready;
            ctrl.pc_write = mem_ready;
        end
        if ((state_q == S_EXECUTE) && jr) begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCS_RS;
        end
        if (reset) begin
            ctrl.pc_write      = 1'b0;
            ctrl.pc_write_cond = 1'b0;
            ctrl.mem_read      = 1'b0;
            ctrl.mem_write     = 1'b0;
            ctrl.ir_write      = 1'b0;
            ctrl.reg_write     = 1'b0;
            illegal            = 1'b0;
        end
    end

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign pc_source     = ctrl.pc_source;
    assign iord          = ctrl.iord;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign zero_ext      = ctrl.zero_ext;
    assign alu_op        = ctrl.alu_op;
    assign illegal_op    = illegal;
    assign state_o       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-instruction phase lists
// feed an expected-output queue that a negedge monitor drains.
module tb_multicycle_control;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       jr;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write;
    logic       ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic       zero_ext, illegal_op;
    logic [1:0] pc_source, alu_src_b, alu_op;
    logic [3:0] state_o;

    multicycle_control #(.RESET_STATE(4'd0)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .jr            (jr),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .zero_ext      (zero_ext),
        .alu_op        (alu_op),
        .illegal_op    (illegal_op),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_ORI  = 6'b001101;

    logic [21:0] exp_q[$];
    logic [5:0]  cur_op;
    int          checks = 0;
    int          errors = 0;
    int          cycle  = 0;

    // Expected outputs for one cycle, straight from the per-state output table
    function automatic logic [21:0] model(state_t st, bit mr, bit jrv,
                                          bit rst, logic [5:0] op);
        bit pw = 0, pwc = 0, io = 0, mrd = 0, mwr = 0, irw = 0;
        bit rd = 0, m2r = 0, rw = 0, sa = 0, ze = 0, ill = 0;
        logic [1:0] ps = 2'b00, sb = 2'b00, ao = 2'b00;
        case (st)
            S_FETCH:   begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
            S_DECODE:  begin
                sb  = 2'b11;
                ill = !(op inside {T_R, T_LW, T_SW, T_BEQ, T_J, T_ADDI, T_ORI});
            end
            S_MEMADR:  begin sa = 1; sb = 2'b10; end
            S_MEMRD:   begin mrd = 1; io = 1; end
            S_MEMWB:   begin rw = 1; m2r = 1; end
            S_MEMWR:   begin mwr = 1; io = 1; end
            S_EXECUTE: begin
                sa = 1; ao = 2'b10;
                if (jrv) begin pw = 1; ps = 2'b11; end
            end
            S_ALUWB:   begin rw = 1; rd = 1; end
            S_BRANCH:  begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
            S_JUMP:    begin pw = 1; ps = 2'b10; end
            S_ADDIEX:  begin sa = 1; sb = 2'b10; end
            S_ORIEX:   begin sa = 1; sb = 2'b10; ao = 2'b11; ze = 1; end
            S_IMMWB:   begin rw = 1; end
            default:   ;
        endcase
        if (rst) begin
            pw = 0; pwc = 0; mrd = 0; mwr = 0; irw = 0; rw = 0; ill = 0;
        end
        return {st, pw, pwc, ps, io, mrd, mwr, irw, rd, m2r, rw,
                sa, sb, ze, ao, ill};
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock of stimulus; expected response goes to the scoreboard
    task automatic cyc(state_t st, bit mr, bit jrv, bit rst);
        @(posedge clk);
        #1;
        reset     = rst;
        mem_ready = mr;
        jr        = jrv;
        opcode    = cur_op;
        exp_q.push_back(model(st, mr, jrv, rst, cur_op));
    endtask

    // Phase sequence of one instruction, with wait cycles in FETCH and memory
    task automatic run_instr(logic [5:0] op, bit jrv, int wf, int wm);
        repeat (wf) cyc(S_FETCH, 0, rb(), 0);
        cyc(S_FETCH, 1, rb(), 0);
        cur_op = op;
        cyc(S_DECODE, rb(), rb(), 0);
        case (op)
            T_LW: begin
                cyc(S_MEMADR, rb(), rb(), 0);
                repeat (wm) cyc(S_MEMRD, 0, rb(), 0);
                cyc(S_MEMRD, 1, rb(), 0);
                cyc(S_MEMWB, rb(), rb(), 0);
            end
            T_SW: begin
                cyc(S_MEMADR, rb(), rb(), 0);
                repeat (wm) cyc(S_MEMWR, 0, rb(), 0);
                cyc(S_MEMWR, 1, rb(), 0);
            end
            T_R: begin
                cyc(S_EXECUTE, rb(), jrv, 0);
                if (!jrv) cyc(S_ALUWB, rb(), rb(), 0);
            end
            T_BEQ:  cyc(S_BRANCH, rb(), rb(), 0);
            T_J:    cyc(S_JUMP, rb(), rb(), 0);
            T_ADDI: begin
                cyc(S_ADDIEX, rb(), rb(), 0);
                cyc(S_IMMWB, rb(), rb(), 0);
            end
            T_ORI: begin
                cyc(S_ORIEX, rb(), rb(), 0);
                cyc(S_IMMWB, rb(), rb(), 0);
            end
            default: ;
        endcase
    endtask

    // Monitor: compare every presented cycle against the scoreboard head
    always @(negedge clk) begin
        logic [21:0] e;
        logic [21:0] a;
        cycle++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {state_o, pc_write, pc_write_cond, pc_source, iord,
                 mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                 reg_write, alu_src_a, alu_src_b, zero_ext, alu_op,
                 illegal_op};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL ctrl cyc=%0d got=%h exp=%h", cycle, a, e);
            end
        end
    end

    initial begin
        logic [5:0] ops [7];
        logic [5:0] op;
        ops = '{T_R, T_LW, T_SW, T_BEQ, T_J, T_ADDI, T_ORI};
        reset     = 1'b1;
        mem_ready = 1'b1;
        jr        = 1'b0;
        cur_op    = T_R;
        opcode    = T_R;
        // reset held for two edges; the second reset cycle is in FETCH
        cyc(S_FETCH, 1, 0, 1);
        cyc(S_FETCH, 1, 0, 0);
        cur_op = T_LW;
        cyc(S_DECODE, 1, 0, 0);
        cyc(S_MEMADR, 1, 0, 0);
        cyc(S_MEMRD, 1, 0, 0);
        cyc(S_MEMWB, 1, 0, 0);
        run_instr(T_LW, 0, 0, 3);
        run_instr(T_R, 1, 0, 0);
        run_instr(T_R, 0, 0, 0);
        run_instr(T_ORI, 0, 0, 0);
        run_instr(T_ADDI, 0, 0, 0);
        run_instr(6'b111111, 0, 0, 0);
        run_instr(T_BEQ, 0, 2, 0);
        run_instr(T_J, 0, 0, 0);
        run_instr(T_SW, 0, 1, 2);
        // reset lands while a store is waiting in MEMWR
        cyc(S_FETCH, 1, 0, 0);
        cur_op = T_SW;
        cyc(S_DECODE, 1, 0, 0);
        cyc(S_MEMADR, 1, 0, 0);
        cyc(S_MEMWR, 0, 0, 0);
        cyc(S_MEMWR, 0, 0, 1);
        cyc(S_FETCH, 1, 0, 0);
        cur_op = T_J;
        cyc(S_DECODE, 1, 0, 0);
        cyc(S_JUMP, 1, 0, 0);
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 5) == 0)
                op = 6'($urandom);
            else
                op = ops[$urandom_range(0, 6)];
            run_instr(op, rb(), $urandom_range(0, 3), $urandom_range(0, 3));
        end
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
